// File: rtl/conv_pkg.sv
`timescale 1ns/1ps
// conv_pkg: shared definitions for the streaming convolution PE.
//   conv_state_e   - frame sequencing states
//   DEFAULT_STRIDE - window step used when a stride of 0 is requested
//   saturate()     - clamps a signed value to the range of a given bit width
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        CALC,
        EMIT,
        SKIP,
        DONE
    } conv_state_e;

    localparam logic [2:0] DEFAULT_STRIDE = 3'd1;

    // Width is a run-time argument so one function serves any OUT_W;
    // callers keep the low bits of the returned value.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                    input int unsigned        width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/conv_mac.sv
`timescale 1ns/1ps
// conv_mac: signed multiply-accumulate.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - synchronous accumulator clear (wins over en)
//   en         - add a*b to the accumulator
//   a, b       - signed operands
//   acc        - signed ACC_W accumulator
module conv_mac #(
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int ACC_W = 18
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [A_W+B_W-1:0] prod;

    assign prod = a * b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/conv_stream_pe.sv
`timescale 1ns/1ps
// conv_stream_pe: streaming 1-D convolution processing element.
// Loads TAPS signed coefficients while idle, then for each frame consumes
// len samples over in_valid/in_ready and emits one result per window
// position (every stride samples) over out_valid/out_ready.
//   start, len, stride        - frame launch (stride 0 behaves as 1)
//   coef_we/addr/wdata        - coefficient write port, honoured only when idle
//   in_valid/in_ready/in_data - sample stream
//   out_valid/out_ready       - result stream; out_data = narrowed (acc >>> SHIFT)
//   out_last                  - marks the final result of the frame
//   busy, done                - not idle / one-cycle end-of-frame pulse
// Build option: CONV_SAT_EN clamps results to the OUT_W signed range,
// otherwise the low OUT_W bits are kept.
module conv_stream_pe
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 4,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 0,
    parameter int LEN_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    input  logic [2:0]              stride,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]       coef_wdata,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);

    localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
    localparam int TAP_W = $clog2(TAPS);

    conv_state_e state, state_next;

    logic [LEN_W-1:0]         len_q;
    logic [LEN_W-1:0]         consumed;
    logic [LEN_W-1:0]         cnt;
    logic [LEN_W-1:0]         skip_n;
    logic [2:0]               stride_q;
    logic                     drain;
    logic [TAP_W-1:0]         tap;
    logic signed [DATA_W-1:0] win  [TAPS];
    logic signed [COEF_W-1:0] coef [TAPS];
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sh;
    logic [LEN_W:0]           reach;
    logic                     accept;
    logic                     tail;
    logic                     fill_full;
    logic                     frame_end;
    logic                     mac_clr;
    logic                     mac_en;

    assign accept    = in_valid & in_ready;
    assign reach     = {1'b0, consumed} + (LEN_W + 1)'(stride_q);
    // Next window would run past the frame: current result is the last one.
    assign tail      = reach > {1'b0, len_q};
    assign fill_full = (cnt + 1'b1) == LEN_W'(TAPS);
    assign frame_end = (consumed + 1'b1) == len_q;

    always_comb begin
        state_next = state;
        mac_clr    = 1'b0;
        mac_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    if (fill_full) begin
                        state_next = CALC;
                        mac_clr    = 1'b1;
                    end else if (frame_end) begin
                        state_next = DONE;
                    end
                end
            end
            CALC: begin
                mac_en = 1'b1;
                if (tap == TAP_W'(TAPS - 1)) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (tail && (consumed == len_q)) begin
                        state_next = DONE;
                    end else begin
                        state_next = SKIP;
                    end
                end
            end
            SKIP: begin
                if (accept && ((cnt + 1'b1) == skip_n)) begin
                    if (drain) begin
                        state_next = DONE;
                    end else begin
                        state_next = CALC;
                        mac_clr    = 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            len_q     <= '0;
            consumed  <= '0;
            cnt       <= '0;
            skip_n    <= '0;
            stride_q  <= DEFAULT_STRIDE;
            drain     <= 1'b0;
            tap       <= '0;
            for (int unsigned i = 0; i < TAPS; i++) begin
                win[i]  <= '0;
                coef[i] <= '0;
            end
        end else begin
            state     <= state_next;
            // Handshake flags are registered from the next state so no
            // input reaches an output combinationally.
            in_ready  <= (state_next == FILL) || (state_next == SKIP);
            out_valid <= (state_next == EMIT);
            out_last  <= (state_next == EMIT) && tail;
            busy      <= (state_next != IDLE);
            done      <= (state_next == DONE);

            if ((state == IDLE) && coef_we) begin
                coef[coef_addr] <= coef_wdata;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        len_q    <= len;
                        stride_q <= (stride == '0) ? DEFAULT_STRIDE : stride;
                        consumed <= '0;
                        cnt      <= '0;
                        drain    <= 1'b0;
                        for (int unsigned i = 0; i < TAPS; i++) begin
                            win[i] <= '0;
                        end
                    end
                end
                FILL, SKIP: begin
                    if (accept) begin
                        for (int unsigned i = 0; i + 1 < TAPS; i++) begin
                            win[i] <= win[i+1];
                        end
                        win[TAPS-1] <= in_data;
                        consumed    <= consumed + 1'b1;
                        cnt         <= cnt + 1'b1;
                    end
                end
                CALC: begin
                    tap <= (tap == TAP_W'(TAPS - 1)) ? '0 : tap + 1'b1;
                end
                EMIT: begin
                    if (out_ready) begin
                        cnt    <= '0;
                        drain  <= tail;
                        // On the final result SKIP swallows whatever is left
                        // of the frame instead of a full stride.
                        skip_n <= tail ? (len_q - consumed) : LEN_W'(stride_q);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    conv_mac #(
        .A_W   (COEF_W),
        .B_W   (DATA_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (coef[tap]),
        .b     (win[tap]),
        .acc   (acc)
    );

    // out_data is decoded from the accumulator register only; it is frozen
    // throughout EMIT because the MAC is enabled solely in CALC.
    assign acc_sh = acc >>> SHIFT;

`ifdef CONV_SAT_EN
    logic signed [63:0] acc_sat;
    logic               unused_sat_hi;
    assign acc_sat       = saturate(64'(acc_sh), OUT_W);
    assign out_data      = acc_sat[OUT_W-1:0];
    assign unused_sat_hi = ^acc_sat[63:OUT_W];
`else
    logic unused_acc_hi;
    assign out_data      = acc_sh[OUT_W-1:0];
    assign unused_acc_hi = ^acc_sh[ACC_W-1:OUT_W];
`endif

endmodule

// File: tb/tb_conv_stream_pe.sv
`timescale 1ns/1ps
// tb_conv_stream_pe: scoreboard bench for conv_stream_pe. Expected results
// for each frame are computed from the convolution definition and queued at
// frame launch; a monitor pops and compares on every output handshake.
module tb_conv_stream_pe;

    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int TAPS   = 4;
    localparam int OUT_W  = 8;
    localparam int SHIFT  = 0;
    localparam int LEN_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  len = '0;
    logic [2:0]        stride = '0;
    logic              coef_we = 1'b0;
    logic [1:0]        coef_addr = '0;
    logic [COEF_W-1:0] coef_wdata = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [OUT_W-1:0]  out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    conv_stream_pe #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .TAPS   (TAPS),
        .OUT_W  (OUT_W),
        .SHIFT  (SHIFT),
        .LEN_W  (LEN_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .stride     (stride),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic [OUT_W-1:0] data;
        logic             last;
    } exp_t;

    exp_t exp_q[$];
    int   frame_data[$];
    int   mdl_coef[TAPS];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_hs_cyc = -10;
    bit   hold = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference result: scaled dot product narrowed to OUT_W.
    function automatic logic [OUT_W-1:0] narrow(input longint acc);
        longint s;
        s = acc >>> SHIFT;
`ifdef CONV_SAT_EN
        if (s > (longint'(1) <<< (OUT_W - 1)) - 1) s = (longint'(1) <<< (OUT_W - 1)) - 1;
        if (s < -(longint'(1) <<< (OUT_W - 1)))    s = -(longint'(1) <<< (OUT_W - 1));
`endif
        return s[OUT_W-1:0];
    endfunction

    // Output back-pressure: random, or held low for the stall test.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = hold ? 1'b0 : ($urandom_range(3) != 0);
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            check("ready_valid_exclusive", in_ready, 1'b0);
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", out_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_last", out_last, e.last);
                    if (e.last) last_hs_cyc = cyc;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  in_ready,  1'b0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_data"},  out_data,  '0);
        check({tag, "_out_last"},  out_last,  1'b0);
        check({tag, "_busy"},      busy,      1'b0);
        check({tag, "_done"},      done,      1'b0);
    endtask

    task automatic load_coefs(input int c0, input int c1, input int c2, input int c3);
        int c[TAPS];
        c = '{c0, c1, c2, c3};
        for (int i = 0; i < TAPS; i++) begin
            coef_we    = 1'b1;
            coef_addr  = 2'(i);
            coef_wdata = COEF_W'(c[i]);
            mdl_coef[i] = c[i];
            @(posedge clk);
            #1;
        end
        coef_we = 1'b0;
    endtask

    task automatic do_start(input int l, input int s);
        start  = 1'b1;
        len    = LEN_W'(l);
        stride = 3'(s);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic feed(input int x);
        bit got;
        in_data  = DATA_W'(x);
        in_valid = 1'b1;
        got = 1'b0;
        for (int g = 0; g < 300 && !got; g++) begin
            @(negedge clk);
            got = in_ready;
        end
        check("sample_accepted", got, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input int l, input int s_in, input bit hold_test);
        int s, n;
        bit adj, got;
        longint acc;
        logic [OUT_W-1:0] held;
        s = (s_in == 0) ? 1 : s_in;
        n = (l >= TAPS) ? ((l - TAPS) / s + 1) : 0;
        for (int k = 0; k < n; k++) begin
            acc = 0;
            for (int i = 0; i < TAPS; i++)
                acc += longint'(mdl_coef[i]) * longint'(frame_data[k * s + i]);
            exp_q.push_back('{narrow(acc), (k == n - 1)});
        end
        adj = (n > 0) && (TAPS + (n - 1) * s == l);
        if (hold_test) hold = 1'b1;
        do_start(l, s_in);
        check("busy_after_start", busy, 1'b1);
        check("in_ready_after_start", in_ready, (l != 0));
        for (int i = 0; i < l; i++) begin
            if ($urandom_range(3) == 0) begin
                @(posedge clk);
                #1;
            end
            feed(frame_data[i]);
        end
        if (hold_test) begin
            got = 1'b0;
            for (int g = 0; g < 100 && !got; g++) begin
                @(negedge clk);
                got = out_valid;
            end
            check("hold_reach_emit", got, 1'b1);
            held = out_data;
            for (int g = 0; g < 10; g++) begin
                @(negedge clk);
                check("hold_out_valid", out_valid, 1'b1);
                check("hold_data_stable", out_data, held);
                check("hold_in_ready_low", in_ready, 1'b0);
            end
            hold = 1'b0;
        end
        got = 1'b0;
        for (int g = 0; g < 500 && !got; g++) begin
            @(negedge clk);
            got = done;
        end
        check("done_seen", got, 1'b1);
        check("results_drained", exp_q.size(), 0);
        if (adj) check("done_after_last_handshake", cyc, last_hs_cyc + 1);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("idle_after_done", busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic fill_seq(input int l);
        frame_data.delete();
        for (int i = 1; i <= l; i++) frame_data.push_back(i);
    endtask

    task automatic fill_rand(input int l);
        frame_data.delete();
        for (int i = 0; i < l; i++) frame_data.push_back(int'($urandom_range(255)) - 128);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < TAPS; i++) mdl_coef[i] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_reset");
        @(posedge clk);
        #1;

        // Unit kernel, stride 1: 10, 14, 18.
        load_coefs(1, 1, 1, 1);
        fill_seq(6);
        run_frame(6, 1, 1'b0);

        // Stride 2 with one trailing sample discarded: 10, 18.
        fill_seq(7);
        run_frame(7, 2, 1'b0);

        // Frame shorter than the kernel: no results.
        fill_seq(3);
        run_frame(3, 1, 1'b0);

        // Empty frame.
        frame_data.delete();
        run_frame(0, 1, 1'b0);

        // Large products: wrap gives 4, saturation gives 127.
        load_coefs(127, 127, 127, 127);
        frame_data.delete();
        for (int i = 0; i < 4; i++) frame_data.push_back(127);
        run_frame(4, 0, 1'b0);

        // Output stall for 10 cycles.
        load_coefs(-3, 7, 2, -5);
        fill_rand(4);
        run_frame(4, 1, 1'b1);

        // Reset in the middle of CALC.
        load_coefs(3, -2, 5, 1);
        do_start(4, 1);
        for (int i = 0; i < 4; i++) feed(int'($urandom_range(255)) - 128);
        #2;
        check("calc_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_calc_reset");
        exp_q.delete();
        for (int i = 0; i < TAPS; i++) mdl_coef[i] = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fill_rand(5);
        run_frame(5, 1, 1'b0);

        // Random frames.
        for (int f = 0; f < 25; f++) begin
            if ((f % 5) == 0) begin
                load_coefs(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                           int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
            end
            fill_rand(int'($urandom_range(16)));
            run_frame(frame_data.size(), int'($urandom_range(7)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
